// File: rtl/canvas_cmd_writer.sv
// Drawing-command engine for the canvas write port (port B): pen colour/position,
// single-pixel plot with auto-advance, clipped rectangle fill and full clear.
module canvas_cmd_writer #(
  parameter int CANVAS_W = 320,
  parameter int CANVAS_H = 240,
  parameter int COL_W    = 9,
  parameter int ROW_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  input  logic [31:0]      cmd_data_i,
  output logic             cmd_ready_o,
  output logic             busy_o,
  output logic             web_o,
  output logic [COL_W-1:0] colb_o,
  output logic [ROW_W-1:0] rowb_o,
  output logic [7:0]       dib_o
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(CANVAS_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(CANVAS_H - 1);

  localparam logic [3:0] OP_COLOR = 4'd1;
  localparam logic [3:0] OP_POS   = 4'd2;
  localparam logic [3:0] OP_PLOT  = 4'd3;
  localparam logic [3:0] OP_FILL  = 4'd4;
  localparam logic [3:0] OP_CLEAR = 4'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic [7:0]       pen_color_r;
  logic [COL_W-1:0] pen_col_r;
  logic [ROW_W-1:0] pen_row_r;

  logic [COL_W-1:0] x_r;
  logic [COL_W-1:0] x0_r;
  logic [COL_W-1:0] xe_r;
  logic [ROW_W-1:0] y_r;
  logic [ROW_W-1:0] ye_r;
  logic [7:0]       fill_color_r;

  logic             web_r;
  logic [COL_W-1:0] colb_r;
  logic [ROW_W-1:0] rowb_r;
  logic [7:0]       dib_r;

  logic [3:0]       opcode_s;
  logic             accept_s;
  logic             fill_last_s;
  logic [COL_W-1:0] pos_col_raw_s;
  logic [ROW_W-1:0] pos_row_raw_s;
  logic [COL_W-1:0] pos_col_s;
  logic [ROW_W-1:0] pos_row_s;
  logic [COL_W:0]   col_sum_s;
  logic [ROW_W:0]   row_sum_s;
  logic [COL_W-1:0] xe_s;
  logic [ROW_W-1:0] ye_s;
  logic [COL_W-1:0] plot_col_next_s;
  logic [ROW_W-1:0] plot_row_next_s;

  assign opcode_s    = cmd_data_i[31:28];
  assign accept_s    = cmd_valid_i && (state_r == ST_IDLE);
  assign fill_last_s = (x_r == xe_r) && (y_r == ye_r);

  // POS operands clamp to the last column/row; FILL extents use one extra bit so the sum cannot wrap.
  assign pos_col_raw_s = cmd_data_i[8 +: COL_W];
  assign pos_row_raw_s = cmd_data_i[0 +: ROW_W];
  assign pos_col_s     = (pos_col_raw_s > COL_MAX) ? COL_MAX : pos_col_raw_s;
  assign pos_row_s     = (pos_row_raw_s > ROW_MAX) ? ROW_MAX : pos_row_raw_s;
  assign col_sum_s     = {1'b0, pen_col_r} + {1'b0, cmd_data_i[16 +: COL_W]};
  assign row_sum_s     = {1'b0, pen_row_r} + {1'b0, cmd_data_i[0 +: ROW_W]};
  assign xe_s          = (col_sum_s > {1'b0, COL_MAX}) ? COL_MAX : col_sum_s[COL_W-1:0];
  assign ye_s          = (row_sum_s > {1'b0, ROW_MAX}) ? ROW_MAX : row_sum_s[ROW_W-1:0];

  // Pen auto-advance after a plot: raster order with wrap at the bottom-right corner
  always_comb begin
    plot_col_next_s = pen_col_r;
    plot_row_next_s = pen_row_r;
    if (pen_col_r == COL_MAX) begin
      plot_col_next_s = {COL_W{1'b0}};
      if (pen_row_r == ROW_MAX) begin
        plot_row_next_s = {ROW_W{1'b0}};
      end else begin
        plot_row_next_s = pen_row_r + ROW_W'(1);
      end
    end else begin
      plot_col_next_s = pen_col_r + COL_W'(1);
      plot_row_next_s = pen_row_r;
    end
  end

  // Next-state logic: FILL/CLEAR start a fill, the (xe,ye) write ends it
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && ((opcode_s == OP_FILL) || (opcode_s == OP_CLEAR))) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (fill_last_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pen state, fill walker and registered write port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pen_color_r  <= 8'h00;
      pen_col_r    <= {COL_W{1'b0}};
      pen_row_r    <= {ROW_W{1'b0}};
      x_r          <= {COL_W{1'b0}};
      x0_r         <= {COL_W{1'b0}};
      xe_r         <= {COL_W{1'b0}};
      y_r          <= {ROW_W{1'b0}};
      ye_r         <= {ROW_W{1'b0}};
      fill_color_r <= 8'h00;
      web_r        <= 1'b0;
      colb_r       <= {COL_W{1'b0}};
      rowb_r       <= {ROW_W{1'b0}};
      dib_r        <= 8'h00;
    end else begin
      web_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (opcode_s)
              OP_COLOR: pen_color_r <= cmd_data_i[7:0];
              OP_POS: begin
                pen_col_r <= pos_col_s;
                pen_row_r <= pos_row_s;
              end
              OP_PLOT: begin
                web_r     <= 1'b1;
                colb_r    <= pen_col_r;
                rowb_r    <= pen_row_r;
                dib_r     <= pen_color_r;
                pen_col_r <= plot_col_next_s;
                pen_row_r <= plot_row_next_s;
              end
              OP_FILL: begin
                x_r          <= pen_col_r;
                x0_r         <= pen_col_r;
                y_r          <= pen_row_r;
                xe_r         <= xe_s;
                ye_r         <= ye_s;
                fill_color_r <= pen_color_r;
              end
              OP_CLEAR: begin
                x_r          <= {COL_W{1'b0}};
                x0_r         <= {COL_W{1'b0}};
                y_r          <= {ROW_W{1'b0}};
                xe_r         <= COL_MAX;
                ye_r         <= ROW_MAX;
                fill_color_r <= cmd_data_i[7:0];
              end
              default: ;
            endcase
          end
        end
        ST_FILL: begin
          web_r  <= 1'b1;
          colb_r <= x_r;
          rowb_r <= y_r;
          dib_r  <= fill_color_r;
          if (x_r == xe_r) begin
            x_r <= x0_r;
            y_r <= y_r + ROW_W'(1);
          end else begin
            x_r <= x_r + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_o = (state_r == ST_IDLE);
  assign busy_o      = (state_r == ST_FILL);
  assign web_o       = web_r;
  assign colb_o      = colb_r;
  assign rowb_o      = rowb_r;
  assign dib_o       = dib_r;

endmodule

// File: tb/tb_canvas_cmd_writer.sv
// Directed self-checking bench for canvas_cmd_writer: plot, wrap, clipped fill,
// full clear, reset abort, ignored opcode and held-while-busy handshake.
module tb_canvas_cmd_writer;

  logic        clk_i;
  logic        rst_i;
  logic        cmd_valid_i;
  logic [31:0] cmd_data_i;
  logic        cmd_ready_o;
  logic        busy_o;
  logic        web_o;
  logic [8:0]  colb_o;
  logic [7:0]  rowb_o;
  logic [7:0]  dib_o;

  int checks   = 0;
  int failures = 0;

  canvas_cmd_writer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_ready_o (cmd_ready_o),
    .busy_o      (busy_o),
    .web_o       (web_o),
    .colb_o      (colb_o),
    .rowb_o      (rowb_o),
    .dib_o       (dib_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int col, input int row, input int dib);
    chk({tag, "_web"}, {31'h0, web_o}, 32'd1);
    chk({tag, "_col"}, {23'h0, colb_o}, col);
    chk({tag, "_row"}, {24'h0, rowb_o}, row);
    chk({tag, "_dib"}, {24'h0, dib_o}, dib);
  endtask

  // Present one command in IDLE; returns 1ns after the accepting edge
  task automatic issue(input logic [31:0] d);
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_data_i  = d;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] c_color(input int c);
    return {4'h1, 20'h0, 8'(c)};
  endfunction
  function automatic logic [31:0] c_pos(input int col, input int row);
    return {4'h2, 11'h0, 9'(col), 8'(row)};
  endfunction
  function automatic logic [31:0] c_plot();
    return {4'h3, 28'h0};
  endfunction
  function automatic logic [31:0] c_fill(input int w1, input int h1);
    return {4'h4, 3'h0, 9'(w1), 8'h00, 8'(h1)};
  endfunction
  function automatic logic [31:0] c_clear(input int c);
    return {4'h5, 20'h0, 8'(c)};
  endfunction

  initial begin
    int low_cnt;
    int busy_cnt;
    int errs;
    int web_cnt;

    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_data_i  = 32'h0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst_ready", {31'h0, cmd_ready_o}, 32'd1);
    chk("rst_busy",  {31'h0, busy_o},      32'd0);
    chk("rst_web",   {31'h0, web_o},       32'd0);
    chk("rst_col",   {23'h0, colb_o},      32'd0);
    chk("rst_row",   {24'h0, rowb_o},      32'd0);
    chk("rst_dib",   {24'h0, dib_o},       32'd0);

    // Colour, position, then three back-to-back plots
    issue(c_color(8'hA5));
    chk("color_noweb", {31'h0, web_o}, 32'd0);
    issue(c_pos(10, 20));
    issue(c_plot());
    chk_wr("plot0", 10, 20, 8'hA5);
    issue(c_plot());
    chk_wr("plot1", 11, 20, 8'hA5);
    issue(c_plot());
    chk_wr("plot2", 12, 20, 8'hA5);
    @(posedge clk_i);
    #1;
    chk("plot_idle_web", {31'h0, web_o}, 32'd0);
    chk("plot_hold_col", {23'h0, colb_o}, 32'd12);

    // Corner wrap, then out-of-range POS clamps to the corner
    issue(c_pos(319, 239));
    issue(c_plot());
    chk_wr("wrap0", 319, 239, 8'hA5);
    issue(c_plot());
    chk_wr("wrap1", 0, 0, 8'hA5);
    issue(c_pos(400, 250));
    issue(c_plot());
    chk_wr("clamp", 319, 239, 8'hA5);

    // Clipped fill; a PLOT held valid during the fill must wait for IDLE
    issue(c_pos(316, 5));
    issue(c_color(8'h3C));
    issue(c_fill(7, 1));
    cmd_valid_i = 1'b1;
    cmd_data_i  = c_plot();
    chk("fill_start_busy", {31'h0, busy_o}, 32'd1);
    chk("fill_start_web",  {31'h0, web_o},  32'd0);
    low_cnt = (cmd_ready_o == 1'b0) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1;
      chk_wr($sformatf("fill%0d", i), 316 + (i % 4), 5 + (i / 4), 8'h3C);
      if (cmd_ready_o == 1'b0) low_cnt++;
    end
    chk("fill_ready_low_cycles", low_cnt, 32'd8);
    chk("fill_end_busy", {31'h0, busy_o}, 32'd0);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    chk_wr("held_plot", 316, 5, 8'h3C);

    // Unknown opcode changes nothing
    issue(32'hF000_00FF);
    chk("opF_web",   {31'h0, web_o},       32'd0);
    chk("opF_ready", {31'h0, cmd_ready_o}, 32'd1);
    issue(c_plot());
    chk_wr("after_opF", 317, 5, 8'h3C);

    // Full clear
    issue(c_clear(8'h00));
    busy_cnt = (busy_o == 1'b1) ? 1 : 0;
    errs     = 0;
    for (int i = 0; i < 76800; i++) begin
      @(posedge clk_i);
      #1;
      if (!(web_o === 1'b1 && colb_o == 9'(i % 320) && rowb_o == 8'(i / 320) && dib_o == 8'h00))
        errs++;
      if (busy_o == 1'b1) busy_cnt++;
    end
    chk("clear_raster_errs", errs, 32'd0);
    chk("clear_busy_cycles", busy_cnt, 32'd76800);
    @(posedge clk_i);
    #1;
    chk("clear_done_web", {31'h0, web_o}, 32'd0);
    chk("clear_done_ready", {31'h0, cmd_ready_o}, 32'd1);
    issue(c_plot());
    chk_wr("clear_pen_kept", 318, 5, 8'h3C);

    // Reset during the third write of a fill
    issue(c_pos(0, 0));
    issue(c_fill(3, 0));
    @(posedge clk_i);
    #1;
    chk_wr("abort_w0", 0, 0, 8'h3C);
    @(posedge clk_i);
    #1;
    chk_wr("abort_w1", 1, 0, 8'h3C);
    @(posedge clk_i);
    #1;
    chk_wr("abort_w2", 2, 0, 8'h3C);
    #1;
    rst_i = 1'b1;
    #1;
    chk("abort_web",   {31'h0, web_o},       32'd0);
    chk("abort_busy",  {31'h0, busy_o},      32'd0);
    chk("abort_ready", {31'h0, cmd_ready_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    web_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1;
      if (web_o == 1'b1) web_cnt++;
    end
    chk("abort_no_writes", web_cnt, 32'd0);
    issue(c_plot());
    chk_wr("abort_pen_reset", 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
